// File: rtl/spi_slave_sv.sv
// -----------------------------------------------------------------------------
// spi_slave_sv
//
// SPI slave endpoint, mode 0 (CPOL=0, CPHA=0), MSB first. All SPI inputs are
// synchronised into the aclk domain and edge-detected there. Each received
// word is presented on rx_data with a one-cycle rx_valid pulse; each word to
// transmit is taken through a tx_valid/tx_ready handshake at a load point
// (CS falling, and the first SCLK falling edge after a completed word).
//
// Ports:
//   aclk          system clock
//   areset        synchronous, active-high reset
//   spi_cs        chip select from master, active low
//   spi_sclk      SPI clock from master, idle low
//   spi_mosi      master-out data
//   spi_miso      slave-out data (registered)
//   tx_data       next word to transmit
//   tx_valid      tx_data is valid
//   tx_ready      tx_data is taken this cycle (load cycles only)
//   rx_data       last complete received word
//   rx_valid      one-cycle pulse: rx_data updated
//   frame_active  slave selected and in ACTIVE
//   tx_underrun   one-cycle pulse: IDLE_WORD was loaded
//   frame_abort   one-cycle pulse: CS deasserted mid-word
// -----------------------------------------------------------------------------
module spi_slave_sv #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = {DATA_WIDTH{1'b1}},
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  spi_cs,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_active,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    // Synchronisers, edge history and start-up qualification
    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q, vld_q;
    logic                   cs_hist_q, sclk_hist_q, armed_q;

    // Protocol state
    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0]  rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   word_done_q, word_done_d;
    logic                   rose_q, rose_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   abort_q, abort_d;
    logic                   miso_q, miso_d;
    logic                   load;

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

    // armed_q blocks the artificial falling edge seen when CS is already low
    // as reset releases: a frame may only start after CS has really been high.
    assign cs_fall   = cs_hist_q & ~cs_s & armed_q;
    assign cs_rise   = ~cs_hist_q & cs_s;
    assign sclk_rise = ~sclk_hist_q & sclk_s;
    assign sclk_fall = sclk_hist_q & ~sclk_s;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        rose_d      = rose_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    load        = 1'b1;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    rose_d      = 1'b0;
                end
            end
            ST_ACTIVE: begin
                // cs_rise has priority; a coincident SCLK edge is dropped.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    abort_d   = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
                    rose_d  = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d   = '0;
                        word_done_d = 1'b1;
                        rx_data_d   = rx_sr_d;
                        rx_valid_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall && rose_q) begin
                    if (bit_cnt_q == '0 && word_done_q) begin
                        load = 1'b1;
                    end else begin
                        tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            if (tx_valid) begin
                tx_sr_d = tx_data;
            end else begin
                tx_sr_d    = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end

        miso_d = (state_d == ST_ACTIVE) ? tx_sr_d[DATA_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // from before this edge; blocking ones would make order matter.
        if (areset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            cs_hist_q   <= 1'b1;
            sclk_hist_q <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            rose_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            // vld_q marks when the last sync stage holds a real sample rather
            // than its reset value.
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            cs_hist_q   <= cs_s;
            sclk_hist_q <= sclk_s;
            armed_q     <= armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            rose_q      <= rose_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
            miso_q      <= miso_d;
        end
    end

    // tx_ready is combinational so the handshake lands in the load cycle itself.
    assign tx_ready     = load & tx_valid & ~areset;
    assign spi_miso     = miso_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign frame_active = (state_q == ST_ACTIVE);
    assign tx_underrun  = underrun_q;
    assign frame_abort  = abort_q;

endmodule

// File: tb/tb_spi_slave_sv.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_sv
//
// Directed bench for spi_slave_sv. A mode-0 master task drives CS/SCLK/MOSI at
// SCLK = aclk/20 and captures MISO on each rising edge. Expected rx words and
// MISO words are pushed into queues when stimulus is issued; a monitor process
// pops and compares them when the DUT pulses rx_valid or the master completes
// a MISO word. A tx FIFO model feeds tx_data/tx_valid and counts handshakes.
// -----------------------------------------------------------------------------
module tb_spi_slave_sv;

    localparam int DW   = 8;
    localparam int HALF = 10;

    logic          aclk = 1'b0;
    logic          areset;
    logic          spi_cs, spi_sclk, spi_mosi, spi_miso;
    logic [DW-1:0] tx_data;
    logic          tx_valid, tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, frame_active, tx_underrun, frame_abort;

    int vectors     = 0;
    int miscompares = 0;
    int ready_cnt   = 0;
    int underrun_cnt = 0;
    int abort_cnt   = 0;

    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] exp_miso[$];
    logic [DW-1:0] got_miso[$];
    logic [DW-1:0] tx_fifo[$];
    logic [DW-1:0] mosi_q[$];

    spi_slave_sv #(
        .DATA_WIDTH (DW),
        .IDLE_WORD  ({DW{1'b1}}),
        .SYNC_STAGES(2)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .spi_cs      (spi_cs),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_active(frame_active),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_counts();
        ready_cnt    = 0;
        underrun_cnt = 0;
        abort_cnt    = 0;
    endtask

    task automatic check_counts(input string tag, input int rdy, input int unr, input int abt);
        check({tag, "_tx_ready_pulses"}, ready_cnt, rdy);
        check({tag, "_underrun_pulses"}, underrun_cnt, unr);
        check({tag, "_abort_pulses"}, abort_cnt, abt);
    endtask

    // tx FIFO model: sample the handshake mid-cycle, pop after the edge.
    initial begin
        bit take;
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge aclk);
            take = tx_ready;
            if (take) ready_cnt++;
            @(posedge aclk);
            #1;
            if (take && tx_fifo.size() > 0) void'(tx_fifo.pop_front());
            tx_valid = (tx_fifo.size() > 0);
            tx_data  = tx_valid ? tx_fifo[0] : '0;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        forever begin
            @(negedge aclk);
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_valid: unexpected pulse with rx_data 0x%0h, none expected", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_rx.pop_front());
                end
            end
            if (tx_underrun) underrun_cnt++;
            if (frame_abort) abort_cnt++;
            if (got_miso.size() > 0) begin
                if (exp_miso.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL miso_word: got 0x%0h, none expected", got_miso.pop_front());
                end else begin
                    check("miso_word", got_miso.pop_front(), exp_miso.pop_front());
                end
            end
        end
    end

    // Mode-0 master: nbits taken from mosi_q, MSB first. The final SCLK fall
    // coincides with CS rising; fewer than a whole number of words aborts.
    task automatic run_frame(input int nbits);
        logic [DW-1:0] w;
        logic [DW-1:0] cap;
        cap     = '0;
        spi_cs  = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            w        = mosi_q[i / DW];
            spi_mosi = w[DW-1 - (i % DW)];
            repeat (HALF) @(negedge aclk);
            cap      = {cap[DW-2:0], spi_miso};
            spi_sclk = 1'b1;
            if (i == 0) check("frame_active_in_frame", frame_active, 1);
            if ((i % DW) == DW - 1) got_miso.push_back(cap);
            repeat (HALF) @(negedge aclk);
            spi_sclk = 1'b0;
            if (i == nbits - 1) spi_cs = 1'b1;
        end
        spi_mosi = 1'b0;
        repeat (2 * HALF) @(negedge aclk);
        check("frame_active_after", frame_active, 0);
        check("miso_after_frame", spi_miso, 0);
        mosi_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        areset   = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge aclk);
        check("reset_miso", spi_miso, 0);
        check("reset_tx_ready", tx_ready, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_active", frame_active, 0);
        check("reset_underrun", tx_underrun, 0);
        check("reset_abort", frame_abort, 0);
        areset = 1'b0;
        repeat (10) @(negedge aclk);

        // Single byte: tx 0xA5, rx 0x3C
        clear_counts();
        tx_fifo.push_back(8'hA5);
        repeat (3) @(negedge aclk);
        mosi_q.push_back(8'h3C);
        exp_rx.push_back(8'h3C);
        exp_miso.push_back(8'hA5);
        run_frame(8);
        check_counts("single", 1, 0, 0);

        // Back-to-back: three words under one CS
        clear_counts();
        tx_fifo.push_back(8'h11);
        tx_fifo.push_back(8'h22);
        tx_fifo.push_back(8'h33);
        repeat (3) @(negedge aclk);
        mosi_q.push_back(8'h01);
        mosi_q.push_back(8'h02);
        mosi_q.push_back(8'h03);
        exp_rx.push_back(8'h01);
        exp_rx.push_back(8'h02);
        exp_rx.push_back(8'h03);
        exp_miso.push_back(8'h11);
        exp_miso.push_back(8'h22);
        exp_miso.push_back(8'h33);
        run_frame(24);
        check_counts("b2b", 3, 0, 0);

        // Underrun: nothing offered, IDLE_WORD goes out
        clear_counts();
        mosi_q.push_back(8'h5A);
        exp_rx.push_back(8'h5A);
        exp_miso.push_back(8'hFF);
        run_frame(8);
        check_counts("underrun", 0, 1, 0);
        check("underrun_rx_data", rx_data, 8'h5A);

        // Abort after 5 rising edges, then a clean frame
        clear_counts();
        mosi_q.push_back(8'hE7);
        run_frame(5);
        check_counts("abort", 0, 1, 1);
        check("abort_rx_data_held", rx_data, 8'h5A);
        clear_counts();
        mosi_q.push_back(8'h81);
        exp_rx.push_back(8'h81);
        exp_miso.push_back(8'hFF);
        run_frame(8);
        check_counts("post_abort", 0, 1, 0);

        // Noise: SCLK toggles with CS high
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            spi_mosi = i[0];
            spi_sclk = ~spi_sclk;
            repeat (HALF) @(negedge aclk);
            check("noise_miso", spi_miso, 0);
        end
        spi_mosi = 1'b0;
        repeat (HALF) @(negedge aclk);
        check_counts("noise", 0, 0, 0);
        check("noise_frame_active", frame_active, 0);

        // Reset mid-word with CS held low, released while CS still low
        clear_counts();
        spi_cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1;
            repeat (HALF) @(negedge aclk);
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge aclk);
            spi_sclk = 1'b0;
        end
        check_counts("pre_reset", 0, 1, 0);
        areset = 1'b1;
        repeat (4) @(negedge aclk);
        check("midreset_miso", spi_miso, 0);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_frame_active", frame_active, 0);
        check("midreset_tx_ready", tx_ready, 0);
        areset = 1'b0;
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            spi_mosi = i[1];
            spi_sclk = ~spi_sclk;
            repeat (HALF) @(negedge aclk);
        end
        spi_mosi = 1'b0;
        check_counts("cs_low_after_reset", 0, 0, 0);
        check("cs_low_frame_active", frame_active, 0);
        check("cs_low_miso", spi_miso, 0);
        check("cs_low_rx_data", rx_data, 0);
        spi_cs = 1'b1;
        repeat (2 * HALF) @(negedge aclk);
        clear_counts();
        mosi_q.push_back(8'hC3);
        exp_rx.push_back(8'hC3);
        exp_miso.push_back(8'hFF);
        run_frame(8);
        check_counts("post_reset", 0, 1, 0);
        check("post_reset_rx_data", rx_data, 8'hC3);

        repeat (5) @(negedge aclk);
        check("exp_rx_left", exp_rx.size(), 0);
        check("exp_miso_left", exp_miso.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
